// File: rtl/object_motion_pkg.sv
// Shared types and saturating helpers for the object motion engine.
package object_motion_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    // Signed add clamped to the two's-complement range of a w-bit value.
    function automatic int sat_add(input int w, input int a, input int b);
        int s;
        int hi;
        int lo;
        s  = a + b;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

    // Negation clamped to w bits; the most negative value maps to the maximum.
    function automatic int sat_neg(input int w, input int a);
        return sat_add(w, -a, 0);
    endfunction

endpackage

// File: rtl/motion_axis_step.sv
// Combinational single-axis update: accelerate, move, then bounce or flag exit.
module motion_axis_step
    import object_motion_pkg::*;
#(
    parameter int POS_W = 10,
    parameter int VEL_W = 8,
    parameter int ACC_W = 4
) (
    input  logic        [POS_W-1:0] p,
    input  logic signed [VEL_W-1:0] v,
    input  logic signed [ACC_W-1:0] a,
    input  logic        [POS_W-1:0] limit,
    input  logic                    bounce,
    output logic        [POS_W-1:0] p_next,
    output logic signed [VEL_W-1:0] v_next,
    output logic                    exit_o
);

    logic signed [VEL_W-1:0] v_new;
    logic signed [POS_W+1:0] p_sum;
    logic        [POS_W-1:0] lim_m1;
    logic                    lo;
    logic                    hi;

    // Position is summed two bits wider so both under- and overflow are visible.
    always_comb begin
        v_new  = VEL_W'(sat_add(VEL_W, int'(v), int'(a)));
        p_sum  = $signed({2'b00, p}) + $signed({{(POS_W+2-VEL_W){v_new[VEL_W-1]}}, v_new});
        lim_m1 = limit - POS_W'(1);
        lo     = p_sum[POS_W+1];
        hi     = !lo && (p_sum > $signed({2'b00, lim_m1}));
        exit_o = 1'b0;
        p_next = p_sum[POS_W-1:0];
        v_next = v_new;
        if (lo || hi) begin
            if (bounce) begin
                p_next = lo ? '0 : lim_m1;
                v_next = VEL_W'(sat_neg(VEL_W, int'(v_new)));
            end else begin
                // Retiring slot keeps its pre-update state.
                exit_o = 1'b1;
                p_next = p;
                v_next = v;
            end
        end
    end

endmodule

// File: rtl/object_motion_bank.sv
// Time-multiplexed motion engine: one slot per cycle per frame tick.
//
//   state | meaning
//   IDLE  | waiting for tick; spawns accepted
//   SWEEP | updating slot idx, one slot per cycle
//   DONE  | one-cycle end-of-sweep marker
module object_motion_bank
    import object_motion_pkg::*;
#(
    parameter  int NUM_OBJ  = 4,
    parameter  int POS_W    = 10,
    parameter  int VEL_W    = 8,
    parameter  int ACC_W    = 4,
    parameter  int SCREEN_W = DEF_SCREEN_W,
    parameter  int SCREEN_H = DEF_SCREEN_H,
    localparam int IDW      = $clog2(NUM_OBJ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic signed [ACC_W-1:0]  ax,
    input  logic signed [ACC_W-1:0]  ay,
    input  logic                     spawn_valid,
    output logic                     spawn_ready,
    input  logic [IDW-1:0]           spawn_id,
    input  logic [POS_W-1:0]         spawn_x,
    input  logic [POS_W-1:0]         spawn_y,
    input  logic signed [VEL_W-1:0]  spawn_vx,
    input  logic signed [VEL_W-1:0]  spawn_vy,
    input  logic                     spawn_bounce,
    input  logic                     kill_valid,
    input  logic [IDW-1:0]           kill_id,
    output logic [NUM_OBJ-1:0]       obj_active,
    output logic [NUM_OBJ*POS_W-1:0] pos_x_flat,
    output logic [NUM_OBJ*POS_W-1:0] pos_y_flat,
    output logic [NUM_OBJ-1:0]       oob_pulse,
    output logic                     busy,
    output logic                     done,
    output logic                     tick_overrun
);

    state_t                  state_q, state_d;
    logic [IDW-1:0]          idx_q, idx_d;
    logic [NUM_OBJ-1:0]      active_q, active_d;
    logic [NUM_OBJ-1:0]      bounce_q, bounce_d;
    logic [NUM_OBJ-1:0]      oob_q, oob_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overrun_q, overrun_d;
    logic [POS_W-1:0]        pos_x_q [NUM_OBJ];
    logic [POS_W-1:0]        pos_x_d [NUM_OBJ];
    logic [POS_W-1:0]        pos_y_q [NUM_OBJ];
    logic [POS_W-1:0]        pos_y_d [NUM_OBJ];
    logic signed [VEL_W-1:0] vel_x_q [NUM_OBJ];
    logic signed [VEL_W-1:0] vel_x_d [NUM_OBJ];
    logic signed [VEL_W-1:0] vel_y_q [NUM_OBJ];
    logic signed [VEL_W-1:0] vel_y_d [NUM_OBJ];

    logic [POS_W-1:0]        px_next, py_next;
    logic signed [VEL_W-1:0] vx_next, vy_next;
    logic                    exit_x, exit_y;

    motion_axis_step #(.POS_W(POS_W), .VEL_W(VEL_W), .ACC_W(ACC_W)) u_step_x (
        .p      (pos_x_q[idx_q]),
        .v      (vel_x_q[idx_q]),
        .a      (ax),
        .limit  (POS_W'(SCREEN_W)),
        .bounce (bounce_q[idx_q]),
        .p_next (px_next),
        .v_next (vx_next),
        .exit_o (exit_x)
    );

    motion_axis_step #(.POS_W(POS_W), .VEL_W(VEL_W), .ACC_W(ACC_W)) u_step_y (
        .p      (pos_y_q[idx_q]),
        .v      (vel_y_q[idx_q]),
        .a      (ay),
        .limit  (POS_W'(SCREEN_H)),
        .bounce (bounce_q[idx_q]),
        .p_next (py_next),
        .v_next (vy_next),
        .exit_o (exit_y)
    );

    assign spawn_ready = (state_q == IDLE);

    // Next state and slot writes; priority low to high: sweep update, kill, spawn.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        active_d  = active_q;
        bounce_d  = bounce_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        vel_x_d   = vel_x_q;
        vel_y_d   = vel_y_q;
        oob_d     = '0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                overrun_d = tick;
                if (active_q[idx_q] && !(kill_valid && kill_id == idx_q)) begin
                    if (exit_x || exit_y) begin
                        active_d[idx_q] = 1'b0;
                        oob_d[idx_q]    = 1'b1;
                    end else begin
                        pos_x_d[idx_q] = px_next;
                        pos_y_d[idx_q] = py_next;
                        vel_x_d[idx_q] = vx_next;
                        vel_y_d[idx_q] = vy_next;
                    end
                end
                if (idx_q == IDW'(NUM_OBJ - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDW'(1);
                end
            end
            DONE: begin
                overrun_d = tick;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (kill_valid) begin
            active_d[kill_id] = 1'b0;
        end
        if (spawn_valid && spawn_ready) begin
            active_d[spawn_id] = 1'b1;
            bounce_d[spawn_id] = spawn_bounce;
            pos_x_d[spawn_id]  = spawn_x;
            pos_y_d[spawn_id]  = spawn_y;
            vel_x_d[spawn_id]  = spawn_vx;
            vel_y_d[spawn_id]  = spawn_vy;
        end
        busy_d = (state_d == SWEEP);
        done_d = (state_d == DONE);
    end

    // State and slot register arrays.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            active_q  <= '0;
            bounce_q  <= '0;
            oob_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
                vel_x_q[i] <= '0;
                vel_y_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            bounce_q  <= bounce_d;
            oob_q     <= oob_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            vel_x_q   <= vel_x_d;
            vel_y_q   <= vel_y_d;
        end
    end

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_flat
        assign pos_x_flat[g*POS_W +: POS_W] = pos_x_q[g];
        assign pos_y_flat[g*POS_W +: POS_W] = pos_y_q[g];
    end

    assign obj_active   = active_q;
    assign oob_pulse    = oob_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tick_overrun = overrun_q;

endmodule
